// File: rtl/mlp_pkg.sv
// ============================================================================
// mlp_pkg : register map, status bits, size limits and sequencer states
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package mlp_pkg;

  localparam logic [7:0] REG_CTRL   = 8'h04;
  localparam logic [7:0] REG_STATUS = 8'h08;
  localparam logic [7:0] REG_CYC    = 8'h0C;
  localparam logic [7:0] REG_N      = 8'h10;
  localparam logic [7:0] REG_M      = 8'h14;
  localparam logic [7:0] REG_H      = 8'h18;

  localparam int CTRL_HOST_EN = 0;
  localparam int CTRL_START   = 1;
  localparam int ST_DONE      = 0;
  localparam int ST_BUSY      = 1;
  localparam int ST_ERR       = 2;

  localparam logic [15:0] MAX_N = 16'd256;
  localparam logic [15:0] MAX_H = 16'd64;
  localparam logic [15:0] MAX_M = 16'd16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_MAC   = 3'd2,
    S_DRAIN = 3'd3,
    S_WR    = 3'd4
  } seq_state_t;

  function automatic logic sizes_valid(logic [15:0] n, logic [15:0] h, logic [15:0] m);
    return (n != 16'd0) && (h != 16'd0) && (m != 16'd0) &&
           (n <= MAX_N) && (h <= MAX_H) && (m <= MAX_M);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mlp_layer_sequencer_if.sv
// ============================================================================
// mlp_layer_sequencer_if : host bus plus memory/MAC control strobes
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface mlp_layer_sequencer_if #(
  parameter int AW    = 16,
  parameter int DW    = 32,
  parameter int IDX_W = 16
);
  logic [AW-1:0]    address;
  logic [DW-1:0]    din;
  logic [DW-1:0]    dout;
  logic             write;
  logic             read;
  logic             host_en;
  logic             layer;
  logic [IDX_W-1:0] in_idx;
  logic [IDX_W-1:0] w_idx;
  logic             mac_clr;
  logic             mac_en;
  logic             res_we;
  logic [IDX_W-1:0] res_idx;

  modport slave (
    input  address, din, write, read,
    output dout, host_en, layer, in_idx, w_idx, mac_clr, mac_en, res_we, res_idx
  );

  modport master (
    output address, din, write, read,
    input  dout, host_en, layer, in_idx, w_idx, mac_clr, mac_en, res_we, res_idx
  );
endinterface

`default_nettype wire

// File: rtl/mlp_reg_file.sv
// ============================================================================
// mlp_reg_file : bus decode, CTRL/N/M/H/STATUS storage and readback mux
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mlp_reg_file
  import mlp_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] din,
  input  logic          write,
  input  logic          busy,
  input  logic          seq_done,
  input  logic [31:0]   cyc_cnt,
  output logic [DW-1:0] dout,
  output logic          host_en,
  output logic [15:0]   n_size,
  output logic [15:0]   h_size,
  output logic [15:0]   m_size,
  output logic          go
);

  logic       in_range;
  logic [7:0] offset;
  logic       wr_ok;
  logic       ctrl_wr;
  logic       start_req;
  logic       done;
  logic       err;
  logic       unused_din;

  assign in_range  = (address[AW-1:8] == '0);
  assign offset    = address[7:0];
  assign wr_ok     = write && in_range && !busy;
  assign ctrl_wr   = wr_ok && (offset == REG_CTRL);
  assign start_req = ctrl_wr && din[CTRL_START];
  assign go        = start_req && sizes_valid(n_size, h_size, m_size);
  assign unused_din = &{1'b0, din[DW-1:16]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      host_en <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
      n_size  <= '0;
      h_size  <= '0;
      m_size  <= '0;
    end else begin
      if (ctrl_wr) begin
        host_en <= din[CTRL_HOST_EN];
        done    <= 1'b0;
        err     <= 1'b0;
        // A rejected start reports completion at once so the host never waits.
        if (start_req && !go) begin
          done <= 1'b1;
          err  <= 1'b1;
        end
        if (go) host_en <= 1'b0;
      end
      if (seq_done) begin
        done    <= 1'b1;
        host_en <= 1'b1;
      end
      if (wr_ok && offset == REG_N) n_size <= din[15:0];
      if (wr_ok && offset == REG_M) m_size <= din[15:0];
      if (wr_ok && offset == REG_H) h_size <= din[15:0];
    end
  end

  always_comb begin
    dout = '0;
    if (in_range) begin
      case (offset)
        REG_CTRL:   dout[CTRL_HOST_EN] = host_en;
        REG_STATUS: begin
          dout[ST_DONE] = done;
          dout[ST_BUSY] = busy;
          dout[ST_ERR]  = err;
        end
        REG_CYC:    dout[31:0] = cyc_cnt;
        REG_N:      dout[15:0] = n_size;
        REG_M:      dout[15:0] = m_size;
        REG_H:      dout[15:0] = h_size;
        default:    dout = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mlp_layer_sequencer.sv
// ============================================================================
// mlp_layer_sequencer : schedules the shared MAC over hidden then output layer
// Optional feature macro SEQ_CYCLE_COUNT_EN adds a busy-cycle counter at 0x0C.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mlp_layer_sequencer
  import mlp_pkg::*;
#(
  parameter int AW    = 16,
  parameter int DW    = 32,
  parameter int IDX_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mlp_layer_sequencer_if.slave bus
);

  seq_state_t  state, state_nxt;
  logic        go;
  logic        busy;
  logic        seq_done;
  logic        layer;
  logic        mac_en;
  logic [15:0] k_cnt, w_cnt, n_cnt;
  logic [15:0] n_size, h_size, m_size;
  logic [15:0] k_last, nr_last;
  logic        last_neuron;
  logic [31:0] cyc_cnt;
  logic        unused_read;

  assign busy        = (state != S_IDLE);
  assign k_last      = (layer ? h_size : n_size) - 16'd1;
  assign nr_last     = (layer ? m_size : h_size) - 16'd1;
  assign last_neuron = (n_cnt == nr_last);
  assign seq_done    = (state == S_WR) && last_neuron && layer;
  assign unused_read = &{1'b0, bus.read};

  mlp_reg_file #(.AW(AW), .DW(DW)) u_reg_file (
    .clk      (clk),
    .reset_n  (reset_n),
    .address  (bus.address),
    .din      (bus.din),
    .write    (bus.write),
    .busy     (busy),
    .seq_done (seq_done),
    .cyc_cnt  (cyc_cnt),
    .dout     (bus.dout),
    .host_en  (bus.host_en),
    .n_size   (n_size),
    .h_size   (h_size),
    .m_size   (m_size),
    .go       (go)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (go) state_nxt = S_CLR;
      S_CLR:   state_nxt = S_MAC;
      S_MAC:   if (k_cnt == k_last) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_WR;
      S_WR:    state_nxt = (last_neuron && layer) ? S_IDLE : S_CLR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // w_cnt runs across neurons so the weight index never needs h*N.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      layer  <= 1'b0;
      k_cnt  <= '0;
      w_cnt  <= '0;
      n_cnt  <= '0;
      mac_en <= 1'b0;
    end else begin
      mac_en <= (state == S_MAC);
      case (state)
        S_IDLE: if (go) begin
          layer <= 1'b0;
          k_cnt <= '0;
          w_cnt <= '0;
          n_cnt <= '0;
        end
        S_CLR: k_cnt <= '0;
        S_MAC: begin
          k_cnt <= k_cnt + 16'd1;
          w_cnt <= w_cnt + 16'd1;
        end
        S_WR: begin
          if (!last_neuron) begin
            n_cnt <= n_cnt + 16'd1;
          end else if (!layer) begin
            layer <= 1'b1;
            n_cnt <= '0;
            w_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_CYCLE_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cyc_cnt <= '0;
    else if (go)   cyc_cnt <= '0;
    else if (busy) cyc_cnt <= cyc_cnt + 32'd1;
  end
`else
  assign cyc_cnt = '0;
`endif

  assign bus.layer   = layer;
  assign bus.in_idx  = IDX_W'(k_cnt);
  assign bus.w_idx   = IDX_W'(w_cnt);
  assign bus.mac_clr = (state == S_CLR);
  assign bus.mac_en  = mac_en;
  assign bus.res_we  = (state == S_WR);
  assign bus.res_idx = IDX_W'(n_cnt);

endmodule

`default_nettype wire

// File: tb/tb_mlp_layer_sequencer.sv
// ============================================================================
// tb_mlp_layer_sequencer : vector table, random sizes and corner sequences
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_mlp_layer_sequencer;
  import mlp_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mlp_layer_sequencer_if #(.AW(16), .DW(32), .IDX_W(16)) bus ();

  mlp_layer_sequencer #(.AW(16), .DW(32), .IDX_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    int n;
    int h;
    int m;
    bit bad;
  } vec_t;

  typedef struct packed {
    logic        l;
    logic [15:0] a;
    logic [15:0] b;
  } ev_t;

  vec_t vecs[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address = a;
    bus.din     = d;
    bus.write   = 1'b1;
    @(negedge clk);
    bus.write   = 1'b0;
    bus.address = '0;
  endtask

  task automatic reg_read(input logic [15:0] a, output logic [31:0] d);
    bus.address = a;
    #1;
    d = bus.dout;
    bus.address = '0;
  endtask

  task automatic set_sizes(input int n, input int h, input int m);
    bus_write(16'h0010, 32'(n));
    bus_write(16'h0018, 32'(h));
    bus_write(16'h0014, 32'(m));
  endtask

  task automatic run_good(input int n, input int h, input int m);
    ev_t em[$];
    ev_t er[$];
    ev_t e, got;
    logic [31:0] st, rd;
    int  s_exp;
    int  busy_cnt = 0, clr_cnt = 0, both = 0;
    int  mac_got = 0, mac_bad = 0, res_got = 0, res_bad = 0;
    int  max0 = -1, max1 = -1;
    bit  done_seen = 0;
    logic        pl = 1'b0;
    logic [15:0] pa = '0, pb = '0;

    for (int hh = 0; hh < h; hh++)
      for (int i = 0; i < n; i++) em.push_back('{1'b0, 16'(i), 16'(hh * n + i)});
    for (int mm = 0; mm < m; mm++)
      for (int hh = 0; hh < h; hh++) em.push_back('{1'b1, 16'(hh), 16'(mm * h + hh)});
    for (int hh = 0; hh < h; hh++) er.push_back('{1'b0, 16'(hh), 16'd0});
    for (int mm = 0; mm < m; mm++) er.push_back('{1'b1, 16'(mm), 16'd0});
    s_exp = h * (n + 3) + m * (h + 3);

    set_sizes(n, h, m);
    bus_write(16'h0004, 32'h2);
    for (int c = 0; c < s_exp + 50; c++) begin
      reg_read(16'h0008, st);
      if (st[ST_BUSY]) busy_cnt++;
      if (st[ST_BUSY] && st[ST_DONE]) both++;
      if (bus.mac_clr) clr_cnt++;
      if (bus.mac_en) begin
        mac_got++;
        got = '{pl, pa, pb};
        if (em.size() == 0) mac_bad++;
        else begin
          e = em.pop_front();
          if (e != got) mac_bad++;
        end
        if (!pl && int'(pb) > max0) max0 = int'(pb);
        if (pl && int'(pb) > max1) max1 = int'(pb);
      end
      if (bus.res_we) begin
        res_got++;
        got = '{bus.layer, bus.res_idx, 16'd0};
        if (er.size() == 0) res_bad++;
        else begin
          e = er.pop_front();
          if (e != got) res_bad++;
        end
      end
      if (st[ST_DONE] && !st[ST_BUSY]) begin
        done_seen = 1;
        break;
      end
      pl = bus.layer;
      pa = bus.in_idx;
      pb = bus.w_idx;
      @(negedge clk);
    end
    chk("done_reached", done_seen, 1);
    chk("busy_cycles", busy_cnt, s_exp);
    chk("busy_done_overlap", both, 0);
    chk("mac_clr_count", clr_cnt, h + m);
    chk("mac_en_count", mac_got, n * h + h * m);
    chk("mac_operand_errs", mac_bad, 0);
    chk("res_we_count", res_got, h + m);
    chk("res_we_errs", res_bad, 0);
    chk("w_idx_max_l0", max0, h * n - 1);
    chk("w_idx_max_l1", max1, m * h - 1);
    chk("host_en_after_done", bus.host_en, 1);
    reg_read(16'h000C, rd);
`ifdef SEQ_CYCLE_COUNT_EN
    chk("cycle_count", rd, s_exp);
`else
    chk("cycle_count", rd, 0);
`endif
    bus_write(16'h0004, 32'h1);
    reg_read(16'h0008, st);
    chk("status_cleared", st, 0);
  endtask

  task automatic run_bad(input int n, input int h, input int m);
    logic [31:0] st;
    int strobes = 0;
    set_sizes(n, h, m);
    bus_write(16'h0004, 32'h2);
    reg_read(16'h0008, st);
    chk("err_status", st, 5);
    for (int c = 0; c < 6; c++) begin
      if (bus.mac_clr || bus.res_we || bus.mac_en) strobes++;
      @(negedge clk);
    end
    chk("err_no_strobes", strobes, 0);
    bus_write(16'h0004, 32'h1);
    reg_read(16'h0008, st);
    chk("err_status_cleared", st, 0);
  endtask

  initial begin
    logic [31:0] rd;
    int n, h, m, busy_after, done_cnt;
    bit prev_done;

    bus.address = '0;
    bus.din     = '0;
    bus.write   = 1'b0;
    bus.read    = 1'b0;

    vecs.push_back('{4, 2, 1, 0});
    vecs.push_back('{1, 1, 1, 0});
    vecs.push_back('{36, 26, 11, 0});
    vecs.push_back('{256, 2, 1, 0});
    vecs.push_back('{3, 64, 16, 0});
    vecs.push_back('{4, 0, 1, 1});
    vecs.push_back('{0, 2, 1, 1});
    vecs.push_back('{4, 2, 0, 1});
    vecs.push_back('{257, 2, 1, 1});
    vecs.push_back('{4, 65, 1, 1});
    vecs.push_back('{4, 2, 17, 1});

    repeat (3) @(negedge clk);
    reg_read(16'h0004, rd);
    chk("reset_ctrl", rd, 1);
    reg_read(16'h0008, rd);
    chk("reset_status", rd, 0);
    reg_read(16'h0010, rd);
    chk("reset_n_size", rd, 0);
    chk("reset_strobes", {bus.mac_clr, bus.mac_en, bus.res_we, bus.w_idx}, 0);
    reset_n = 1'b1;
    bus.read = 1'b1;

    for (int v = 0; v < vecs.size(); v++) begin
      if (vecs[v].bad) run_bad(vecs[v].n, vecs[v].h, vecs[v].m);
      else             run_good(vecs[v].n, vecs[v].h, vecs[v].m);
    end

    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 20));
      h = int'($urandom_range(1, 8));
      m = int'($urandom_range(1, 5));
      run_good(n, h, m);
    end

    // Writes while busy must be dropped and must not retrigger.
    set_sizes(4, 2, 1);
    bus_write(16'h0004, 32'h2);
    bus_write(16'h0010, 32'd7);
    bus_write(16'h0004, 32'h2);
    reg_read(16'h0010, rd);
    chk("busy_n_write_ignored", rd, 4);
    done_cnt = 0;
    busy_after = 0;
    prev_done = 0;
    for (int c = 0; c < 60; c++) begin
      reg_read(16'h0008, rd);
      if (rd[ST_DONE] && !prev_done) done_cnt++;
      prev_done = rd[ST_DONE];
      if (rd[ST_DONE] && rd[ST_BUSY]) busy_after++;
      if (prev_done && rd[ST_BUSY]) busy_after++;
      @(negedge clk);
    end
    chk("single_done_pulse", done_cnt, 1);
    chk("no_restart", busy_after, 0);
    bus_write(16'h0004, 32'h1);

    // Asynchronous reset in the middle of the hidden-layer MAC run.
    set_sizes(8, 2, 1);
    bus_write(16'h0004, 32'h2);
    repeat (4) @(negedge clk);
    chk("pre_reset_mac_en", bus.mac_en, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_strobes", {bus.mac_clr, bus.mac_en, bus.res_we, bus.in_idx}, 0);
    reg_read(16'h0008, rd);
    chk("async_status", rd, 0);
    reg_read(16'h0004, rd);
    chk("async_ctrl", rd, 1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    reg_read(16'h0008, rd);
    chk("post_reset_idle", rd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
